// File: rtl/midi_pkg.sv
// midi_pkg: shared definitions for the MIDI serial receiver.
//   rx_state_t  - receiver state encoding (IDLE, START, DATA, STOP, BREAK)
//   MIDI_BAUD   - standard MIDI bit rate
//   calc_ticks  - clock cycles per serial bit for a given clock and baud rate
package midi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int MIDI_BAUD = 31250;

  // Whole clock cycles per bit period; any remainder is simply dropped.
  function automatic int calc_ticks(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/midi_sync.sv
// midi_sync: multi-stage synchroniser for the asynchronous serial line.
// Every stage resets to 1 (the idle line level), so leaving reset never
// looks like a falling start edge.
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   d    in   asynchronous input
//   q    out  synchronised output, STAGES cycles behind d
module midi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: MIDI-style asynchronous receiver (1 start, DATA_BITS data
// LSB-first, 1 stop) with start-glitch rejection, framing check and a
// valid/ready output with overrun reporting.
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   midi_signal    in   asynchronous serial line, idles high
//   rx_data        out  last received byte, stable while rx_valid=1
//   rx_valid       out  byte available, held until accepted
//   rx_ready       in   consumer accepts when rx_valid && rx_ready
//   framing_error  out  one-cycle pulse when the stop bit is sampled low
//   overrun        out  one-cycle pulse when an unaccepted byte is replaced
//   busy           out  high while the receiver is not idle
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = MIDI_BAUD,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 midi_signal,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TICKS = calc_ticks(CLK_HZ, BAUD);
  localparam int HALF  = TICKS / 2;
  localparam int CW    = $clog2(TICKS);
  localparam int BW    = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 s_in_s;
  rx_state_t            state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [BW-1:0]        bit_r, bit_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 load_s;
  logic                 ferr_s;

  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 ferr_r;
  logic                 ovr_r;
  logic                 busy_r;

  midi_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (midi_signal),
    .q   (s_in_s)
  );

  // Frame state machine: next state, bit timing counter and shift register.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + CW'(1);
    bit_s   = bit_r;
    shift_s = shift_r;
    load_s  = 1'b0;
    ferr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = {CW{1'b0}};
        if (!s_in_s) begin
          state_s = START;
          bit_s   = {BW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        // Re-check the line half a bit in; a short low pulse is a glitch.
        if (cnt_r == CNT_HALF) begin
          if (s_in_s) begin
            state_s = IDLE;
          end else begin
            state_s = DATA;
            cnt_s   = {CW{1'b0}};
          end
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s   = {CW{1'b0}};
          shift_s = {s_in_s, shift_r[DATA_BITS-1:1]};
          bit_s   = bit_r + BW'(1);
          if (bit_r == BIT_LAST) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        // Leave at mid stop bit so a directly following start edge is seen.
        if (cnt_r == CNT_LAST) begin
          cnt_s = {CW{1'b0}};
          if (s_in_s) begin
            load_s  = 1'b1;
            state_s = IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = BREAK;
          end
        end else begin
          state_s = STOP;
        end
      end
      BREAK: begin
        // A held-low line reports one framing error, then waits for idle.
        cnt_s = {CW{1'b0}};
        if (s_in_s) begin
          state_s = IDLE;
        end else begin
          state_s = BREAK;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Receiver state, counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      bit_r   <= {BW{1'b0}};
      shift_r <= {DATA_BITS{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
    end
  end

  // Output register: byte hand-off, handshake, error pulses and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_r  <= {DATA_BITS{1'b0}};
      rx_valid_r <= 1'b0;
      ferr_r     <= 1'b0;
      ovr_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      ferr_r <= ferr_s;
      busy_r <= (state_s != IDLE);
      if (load_s) begin
        // A new byte wins over a simultaneous handshake; only an
        // unaccepted old byte counts as overrun.
        rx_data_r  <= shift_r;
        rx_valid_r <= 1'b1;
        ovr_r      <= rx_valid_r & ~rx_ready;
      end else begin
        ovr_r <= 1'b0;
        if (rx_valid_r && rx_ready) begin
          rx_valid_r <= 1'b0;
        end else begin
          rx_valid_r <= rx_valid_r;
        end
      end
    end
  end

  assign rx_data       = rx_data_r;
  assign rx_valid      = rx_valid_r;
  assign framing_error = ferr_r;
  assign overrun       = ovr_r;
  assign busy          = busy_r;

endmodule
